// File: rtl/pdn_pipe.sv
// pdn_pipe -- two-stage pipelined permutation deflection network (MinBD router).
//
// Four flits (lanes N,S,E,W = 0..3) enter each cycle and leave on the four
// output ports exactly two cycles later. Nothing is dropped or held back.
// Stage 1 pairs {N,E} (A) and {S,W} (B). Each pair is steered toward the N/S
// half (output 0) or the E/W half (output 1). Stage 2 has two arbiters. The
// N/S arbiter takes A0/B0 and drives ports N/S. The E/W arbiter takes A1/B1
// and drives ports E/W. Contention is resolved by age (prio). Ties are broken
// by a per-arbiter toggle. A flit leaving on a port other than its dir is
// deflected, and its prio is incremented (saturating).
//
// Optional feature: define PDN_DEFL_CNT_EN to build per-output deflection
// counters together with the defl_clr / defl_cnt ports.
//
// Ports:
//   clk, rst   clock (rising edge); asynchronous active-high reset
//   in_valid   [3:0]          per-lane valid (0=N 1=S 2=E 3=W)
//   in_flit    [4*FLIT_W-1:0] payloads, lane i at [i*FLIT_W +: FLIT_W]
//   in_dir     [7:0]          desired output per lane (0=N 1=S 2=E 3=W)
//   in_prio    [4*PRIO_W-1:0] age per lane
//   out_valid/out_flit/out_dir/out_prio  per output port, same packing
//   out_defl   [3:0]          flit left on a port other than its dir
//   defl_clr   sync clear of counters           (PDN_DEFL_CNT_EN only)
//   defl_cnt   [4*CNT_W-1:0] per-port counts     (PDN_DEFL_CNT_EN only)
module pdn_pipe #(
    parameter int FLIT_W = 11,
    parameter int PRIO_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          in_valid,
    input  logic [4*FLIT_W-1:0] in_flit,
    input  logic [7:0]          in_dir,
    input  logic [4*PRIO_W-1:0] in_prio,
    output logic [3:0]          out_valid,
    output logic [4*FLIT_W-1:0] out_flit,
    output logic [7:0]          out_dir,
    output logic [4*PRIO_W-1:0] out_prio,
    output logic [3:0]          out_defl
`ifdef PDN_DEFL_CNT_EN
    ,
    input  logic                defl_clr,
    output logic [4*CNT_W-1:0]  defl_cnt
`endif
);

    typedef struct packed {
        logic              v;
        logic [1:0]        dir;
        logic [PRIO_W-1:0] prio;
        logic [FLIT_W-1:0] flit;
    } flit_t;

    localparam logic [PRIO_W-1:0] PRIO_MAX = '1;

    // 2x2 arbiter decision. pf = preferred output (0/1) of each input.
    // Returns {tie, swap}: swap=1 routes input0 to output1 and input1 to output0.
    function automatic logic [1:0] arb2(input flit_t f0, input logic pf0,
                                        input flit_t f1, input logic pf1,
                                        input logic tog);
        logic swap;
        logic tie;
        logic win1;
        swap = 1'b0;
        tie  = 1'b0;
        win1 = 1'b0;
        if (f0.v && f1.v) begin
            if (pf0 != pf1) begin
                swap = pf0;
            end else begin
                tie  = (f0.prio == f1.prio);
                win1 = tie ? tog : (f1.prio > f0.prio);
                // the winner takes the shared preference, the loser the other output
                swap = win1 ? ~pf0 : pf0;
            end
        end else if (f0.v) begin
            swap = pf0;
        end else if (f1.v) begin
            swap = ~pf1;
        end
        return {tie, swap};
    endfunction

    flit_t      lane_in [4];
    flit_t      s1_d    [4];   // [0]=A0 [1]=A1 [2]=B0 [3]=B1
    flit_t      s1_q    [4];
    flit_t      s2_d    [4];   // indexed by output port
    flit_t      exit_d  [4];
    flit_t      out_q   [4];
    logic [3:0] defl_d;
    logic [3:0] defl_q;
    logic [1:0] tie_s1;
    logic [1:0] tie_s2;
    logic [3:0] tog_q;         // [0]=A [1]=B [2]=N/S [3]=E/W
    logic [3:0] tog_d;

    genvar gi;

    // Invalid slots are forced to all-zero so they carry nothing downstream.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_in[gi] = in_valid[gi] ?
                {1'b1, in_dir[2*gi +: 2], in_prio[gi*PRIO_W +: PRIO_W],
                 in_flit[gi*FLIT_W +: FLIT_W]} : '0;
        end
    endgenerate

    // Stage 1: pair A = lanes 0/2, pair B = lanes 1/3. dir[1]=0 means N or S.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_s1
            flit_t      i0;
            flit_t      i1;
            logic [1:0] r;
            assign i0 = lane_in[gi];
            assign i1 = lane_in[gi+2];
            assign r  = arb2(i0, i0.dir[1], i1, i1.dir[1], tog_q[gi]);
            assign s1_d[2*gi]   = r[0] ? i1 : i0;
            assign s1_d[2*gi+1] = r[0] ? i0 : i1;
            assign tie_s1[gi]   = r[1];
        end
    endgenerate

    // Stage 2: arbiter 0 (N/S) takes A0/B0, arbiter 1 (E/W) takes A1/B1.
    // Output 0 is the arbiter's home port (N or E); any other dir prefers output 1.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_s2
            localparam logic [1:0] HOME = 2'(2*gi);
            flit_t      i0;
            flit_t      i1;
            logic [1:0] r;
            assign i0 = s1_q[gi];
            assign i1 = s1_q[gi+2];
            assign r  = arb2(i0, i0.dir != HOME, i1, i1.dir != HOME, tog_q[gi+2]);
            assign s2_d[2*gi]   = r[0] ? i1 : i0;
            assign s2_d[2*gi+1] = r[0] ? i0 : i1;
            assign tie_s2[gi]   = r[1];
        end
    endgenerate

    // Exit: mark deflection and age the deflected flit (saturating).
    generate
        for (gi = 0; gi < 4; gi++) begin : g_exit
            logic [PRIO_W-1:0] prio_x;
            assign defl_d[gi] = s2_d[gi].v && (s2_d[gi].dir != 2'(gi));
            assign prio_x     = (defl_d[gi] && (s2_d[gi].prio != PRIO_MAX)) ?
                                s2_d[gi].prio + 1'b1 : s2_d[gi].prio;
            assign exit_d[gi] = {s2_d[gi].v, s2_d[gi].dir, prio_x, s2_d[gi].flit};

            assign out_valid[gi]                   = out_q[gi].v;
            assign out_flit[gi*FLIT_W +: FLIT_W]   = out_q[gi].flit;
            assign out_dir[2*gi +: 2]              = out_q[gi].dir;
            assign out_prio[gi*PRIO_W +: PRIO_W]   = out_q[gi].prio;
            assign out_defl[gi]                    = defl_q[gi];
        end
    endgenerate

    // A toggle flips only on a cycle where its arbiter actually decided a tie.
    assign tog_d = tog_q ^ {tie_s2, tie_s1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                s1_q[i]  <= '0;
                out_q[i] <= '0;
            end
            defl_q <= '0;
            tog_q  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                s1_q[i]  <= s1_d[i];
                out_q[i] <= exit_d[i];
            end
            defl_q <= defl_d;
            tog_q  <= tog_d;
        end
    end

`ifdef PDN_DEFL_CNT_EN
    // Counters advance on the same edge that registers a deflected output.
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            assign cnt_d[gi] = defl_clr ? '0 :
                               (defl_d[gi] && (cnt_q[gi] != '1)) ? cnt_q[gi] + 1'b1 :
                               cnt_q[gi];
            assign defl_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`endif

endmodule
